// File: rtl/ifetch_pkg.sv
// Shared fetch-path definitions: FSM state encoding, fetch stride and buffer sizing.
package ifetch_pkg;

  localparam int unsigned FETCH_STRIDE = 4;
  localparam int unsigned FIFO_DEPTH   = 2;
  localparam int unsigned CNT_W        = 2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory port and decode handshake.
interface ifetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] pc_w_i;
  logic              redirect_w_i;
  logic              mem_req_w_o;
  logic [ADDR_W-1:0] mem_addr_w_o;
  logic              mem_gnt_w_i;
  logic              mem_rvalid_w_i;
  logic [DATA_W-1:0] mem_rdata_w_i;
  logic              instr_valid_w_o;
  logic [DATA_W-1:0] instr_w_o;
  logic [ADDR_W-1:0] instr_pc_w_o;
  logic              instr_ready_w_i;

  modport master (
    input  pc_w_i, redirect_w_i, mem_gnt_w_i, mem_rvalid_w_i, mem_rdata_w_i, instr_ready_w_i,
    output mem_req_w_o, mem_addr_w_o, instr_valid_w_o, instr_w_o, instr_pc_w_o
  );

  modport slave (
    output pc_w_i, redirect_w_i, mem_gnt_w_i, mem_rvalid_w_i, mem_rdata_w_i, instr_ready_w_i,
    input  mem_req_w_o, mem_addr_w_o, instr_valid_w_o, instr_w_o, instr_pc_w_o
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry shifting instruction buffer; the head always sits in head_q so it can drive
// outputs straight from a flop. Flush wins over push and pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] slot;
  logic             full_q, empty_q;
  logic             pop_ok, push_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop_ok);
    slot    = cnt_q - CNT_W'(pop_ok);
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_ok) head_d = tail_q;
      // A push lands in whichever slot is free once this cycle's pop has shifted.
      if (push_ok) begin
        if (slot == '0) head_d = wdata_i;
        else            tail_d = wdata_i;
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(FIFO_DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign head_o  = head_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory read, two-entry instruction buffer,
// redirect flushes the buffer and discards any in-flight response.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input logic      clk_w_i,
  input logic      res_w_i_l,
  ifetch_if.master bus
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              grant;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  occ_d;

  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;

  // Response in WAIT belongs to the address just before the advanced fetch pointer.
  assign fifo_wdata = {bus.mem_rdata_w_i, fetch_q - ADDR_W'(FETCH_STRIDE)};

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    req_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    occ_d   = fifo_cnt;
    grant   = req_q && bus.mem_gnt_w_i;
    if (bus.redirect_w_i) begin
      flush   = 1'b1;
      fetch_d = bus.pc_w_i & ~(ADDR_W'(FETCH_STRIDE) - ADDR_W'(1));
      unique case (state_q)
        ST_RUN:           if (grant) state_d = ST_DROP;
        ST_WAIT, ST_DROP: state_d = bus.mem_rvalid_w_i ? ST_RUN : ST_DROP;
        default:          state_d = ST_RUN;
      endcase
    end else begin
      pop = bus.instr_ready_w_i && !fifo_empty;
      unique case (state_q)
        ST_RUN: begin
          if (grant) begin
            state_d = ST_WAIT;
            fetch_d = fetch_q + ADDR_W'(FETCH_STRIDE);
          end
        end
        ST_WAIT: begin
          if (bus.mem_rvalid_w_i) begin
            push    = !fifo_full || pop;
            state_d = ST_RUN;
          end
        end
        ST_DROP: if (bus.mem_rvalid_w_i) state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
      // Request only when nothing is in flight and the buffer will have room.
      occ_d = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      req_d = (state_d == ST_RUN) && (occ_d < CNT_W'(FIFO_DEPTH));
    end
    addr_d = fetch_d;
  end

  always_ff @(posedge clk_w_i) begin
    if (!res_w_i_l) begin
      state_q <= ST_RUN;
      fetch_q <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  ifetch_fifo #(
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i   (clk_w_i),
    .rst_ni  (res_w_i_l),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus.mem_req_w_o     = req_q;
  assign bus.mem_addr_w_o    = addr_q;
  assign bus.instr_valid_w_o = !fifo_empty;
  assign bus.instr_w_o       = fifo_head[ENT_W-1:ADDR_W];
  assign bus.instr_pc_w_o    = fifo_head[ADDR_W-1:0];

endmodule
